// File: rtl/affine_tap_accum_if.sv
// Tap-product stream in, filtered-pixel stream out, plus the framing-error pulse.
interface affine_tap_accum_if #(
  parameter int PROD_W = 15,
  parameter int OUT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_pix;
  logic                     err;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_pix, err
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_pix, err
  );
endinterface

// File: rtl/affine_tap_accum.sv
// Sums NTAPS signed tap products per sample, rounds, shifts by SHIFT and
// saturates into a one-entry output register with valid/ready handoff.
module affine_tap_accum #(
  parameter int PROD_W = 15,
  parameter int NTAPS  = 6,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  affine_tap_accum_if.slave  bus
);
  localparam int ACC_W = PROD_W + 3;
  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CNT_W-1:0]    LAST_T = CNT_W'(NTAPS - 1);
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic signed [ACC_W:0] PMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] NMIN = (ACC_W+1)'(-(2**(OUT_W-1)));

  // Round half up, then floor via arithmetic shift; one guard bit absorbs RND.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(s) + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] r);
    logic signed [ACC_W:0] c;
    if (r > PMAX)      c = PMAX;
    else if (r < NMIN) c = NMIN;
    else               c = r;
    return c[OUT_W-1:0];
  endfunction

  logic [CNT_W-1:0]        tcnt;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] sum_p0;
  logic signed [OUT_W-1:0] out_pix_p1;
  logic                    vld_p1;
  logic                    err_p1;
  logic                    is_final, xfer, hand, load, frame_err, ready;

  assign prod_x    = ACC_W'(bus.in_prod);
  assign sum_p0    = acc_p0 + prod_x;
  assign is_final  = (tcnt == LAST_T);
  // Only the final tap can stall: it needs the output register free or draining.
  assign ready     = !(is_final && vld_p1 && !bus.out_ready);
  assign xfer      = bus.in_valid && ready;
  assign hand      = vld_p1 && bus.out_ready;
  assign load      = xfer && is_final && bus.in_last;
  assign frame_err = xfer && (bus.in_last != is_final);

  // Stage p0: tap accumulation and framing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt   <= '0;
      acc_p0 <= '0;
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= frame_err;
      if (frame_err || load) begin
        tcnt   <= '0;
        acc_p0 <= '0;
      end else if (xfer) begin
        tcnt   <= tcnt + CNT_W'(1);
        acc_p0 <= (tcnt == '0) ? prod_x : sum_p0;
      end
    end
  end

  // Stage p1: normalised output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pix_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (load) begin
      out_pix_p1 <= saturate(round_shift(sum_p0));
      vld_p1     <= 1'b1;
    end else if (hand) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_pix   = out_pix_p1;
  assign bus.err       = err_p1;
endmodule

// File: tb/tb_affine_tap_accum.sv
// Randomised and directed bench for affine_tap_accum against a sample-level model.
module tb_affine_tap_accum;
  localparam int PROD_W = 15;
  localparam int NTAPS  = 6;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  affine_tap_accum_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();
  affine_tap_accum #(.PROD_W(PROD_W), .NTAPS(NTAPS), .SHIFT(SHIFT), .OUT_W(OUT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample-level model: pending outputs, taps seen so far, running sum.
  int q[$];
  int hist[$];
  int m_cnt = 0;
  int m_sum = 0;
  bit err_exp = 0;
  int errs_seen = 0;

  function automatic int norm(input int s);
    int v, r, d;
    d = 1 << SHIFT;
    v = s + (1 << (SHIFT - 1));
    r = (v >= 0) ? v / d : -((-v + d - 1) / d);
    if (r > 2**(OUT_W-1) - 1) r = 2**(OUT_W-1) - 1;
    if (r < -(2**(OUT_W-1)))  r = -(2**(OUT_W-1));
    return r;
  endfunction

  always @(negedge clk) begin
    bit rdy_exp;
    int pv;
    if (rst) begin
      chk("rst_vld", int'(bus.out_valid), 0);
      chk("rst_pix", int'(bus.out_pix), 0);
      chk("rst_rdy", int'(bus.in_ready), 1);
      chk("rst_err", int'(bus.err), 0);
      q.delete();
      m_cnt = 0; m_sum = 0; err_exp = 0;
    end else begin
      chk("err", int'(bus.err), int'(err_exp));
      if (bus.err) errs_seen++;
      chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
      if (q.size() != 0) chk("out_pix", int'(bus.out_pix), q[0]);
      rdy_exp = !(m_cnt == NTAPS-1 && q.size() != 0 && !bus.out_ready);
      chk("in_ready", int'(bus.in_ready), int'(rdy_exp));
      err_exp = 0;
      if (q.size() != 0 && bus.out_ready) hist.push_back(q.pop_front());
      if (bus.in_valid && rdy_exp) begin
        pv = int'(bus.in_prod);
        if (bus.in_last != (m_cnt == NTAPS-1)) begin
          err_exp = 1; m_cnt = 0; m_sum = 0;
        end else if (m_cnt == NTAPS-1) begin
          q.push_back(norm(m_sum + pv)); m_cnt = 0; m_sum = 0;
        end else begin
          m_sum += pv; m_cnt++;
        end
      end
    end
  end

  // Single driver of out_ready: random or a fixed level.
  bit rnd_or = 0;
  bit or_fixed = 1;
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : or_fixed;
  end

  bit gaps = 0;
  int tap_buf[NTAPS];

  task automatic put_tap(input int p, input bit l);
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_prod  = PROD_W'($urandom);
        bus.in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_prod  = PROD_W'(p);
    bus.in_last  = l;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_buf(input int n, input int last_at);
    for (int i = 0; i < n; i++) put_tap(tap_buf[i], i == last_at);
  endtask

  task automatic set_taps(input int a, b, c, d, e, f);
    tap_buf[0] = a; tap_buf[1] = b; tap_buf[2] = c;
    tap_buf[3] = d; tap_buf[4] = e; tap_buf[5] = f;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int hs, es;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_prod  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic rounding: 60 -> 1
    hs = hist.size(); es = errs_seen;
    set_taps(10, 10, 10, 10, 10, 10); send_buf(6, 5); settle();
    chk("basic_cnt", hist.size() - hs, 1);
    chk("basic_pix", hist[$], 1);
    chk("basic_err", errs_seen - es, 0);

    set_taps(0, 0, 8128, 0, 0, 0); send_buf(6, 5); settle();
    chk("pos_edge", hist[$], 127);
    set_taps(0, 0, -8192, 0, 0, 0); send_buf(6, 5); settle();
    chk("neg_edge", hist[$], -128);
    set_taps(0, 0, 8128, 8128, 0, 0); send_buf(6, 5); settle();
    chk("sat_pos", hist[$], 127);
    set_taps(-8192, -8192, 0, 0, 0, 0); send_buf(6, 5); settle();
    chk("sat_neg", hist[$], -128);

    // Back-pressure on the final tap with simultaneous handoff and load
    or_fixed = 0; settle();
    hs = hist.size();
    set_taps(0, 0, 8128, 0, 0, 0); send_buf(6, 5);
    set_taps(64, 64, 64, 64, 64, 64);
    fork
      send_buf(6, 5);
      begin
        repeat (12) @(negedge clk);
        chk("stall_ready", int'(bus.in_ready), 0);
        chk("stall_hold", int'(bus.out_pix), 127);
        or_fixed = 1;
      end
    join
    settle();
    chk("bp_cnt", hist.size() - hs, 2);
    chk("bp_old", hist[hs], 127);
    chk("bp_new", hist[$], 6);

    // Early last on tap 2
    hs = hist.size(); es = errs_seen;
    set_taps(5, 5, 5, 0, 0, 0); send_buf(3, 2); settle();
    chk("early_err", errs_seen - es, 1);
    chk("early_noout", hist.size() - hs, 0);
    set_taps(64, 64, 64, 64, 64, 64); send_buf(6, 5); settle();
    chk("after_early", hist[$], 6);

    // Missing last on the final tap
    es = errs_seen; hs = hist.size();
    set_taps(100, 100, 100, 100, 100, 100); send_buf(6, -1); settle();
    chk("late_err", errs_seen - es, 1);
    set_taps(10, 10, 10, 10, 10, 10); send_buf(6, 5); settle();
    chk("after_late_cnt", hist.size() - hs, 1);
    chk("after_late", hist[$], 1);

    // Reset mid-sample with a pending output
    or_fixed = 0; settle();
    hs = hist.size();
    set_taps(0, 0, 8128, 0, 0, 0); send_buf(6, 5);
    set_taps(10, 10, 10, 10, 10, 10); send_buf(3, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", int'(bus.out_valid), 0);
    chk("mid_rst_pix", int'(bus.out_pix), 0);
    @(posedge clk); #1 rst = 1'b0;
    or_fixed = 1; settle();
    send_buf(6, 5); settle();
    chk("rst_cnt", hist.size() - hs, 1);
    chk("rst_pix_after", hist[$], 1);

    // Randomised traffic with occasional framing errors
    rnd_or = 1; gaps = 1;
    for (int s = 0; s < 150; s++) begin
      int la;
      for (int i = 0; i < NTAPS; i++) tap_buf[i] = int'($urandom_range(0, 32767)) - 16384;
      la = 5;
      if ($urandom_range(0, 15) == 0) la = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, 4));
      send_buf((la == -1 || la == 5) ? 6 : la + 1, la);
    end
    rnd_or = 0; gaps = 0; or_fixed = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_vld", int'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/affine_tap_accum.md
AFFINE_TAP_ACCUM -- requirements
Module: affine_tap_accum

Interface
REQ-001 Parameter PROD_W, default 15: signed width of one tap product (8-bit sample x coefficient up to 64).
REQ-002 Parameter NTAPS, default 6: tap products per output sample.
REQ-003 Parameter SHIFT, default 6: normalisation shift, since the coefficient sum is 64.
REQ-004 Parameter OUT_W, default 8: signed width of the output sample.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, 1: in_prod carries a valid tap product.
REQ-008 Port in_ready, output, 1: the block accepts in_prod this cycle.
REQ-009 Port in_prod, input, PROD_W: signed tap product, tap 0 first.
REQ-010 Port in_last, input, 1: in_prod is the final tap of the current sample.
REQ-011 Port out_valid, output, 1: out_pix holds a completed sample.
REQ-012 Port out_ready, input, 1: the downstream consumer takes out_pix.
REQ-013 Port out_pix, output, OUT_W: signed, normalised, saturated filtered sample.
REQ-014 Port err, output, 1: one-cycle pulse on a tap-framing error.

Function
REQ-015 A transfer occurs on a rising edge where in_valid and in_ready are both high; an output handoff occurs where out_valid and out_ready are both high.
REQ-016 State: tap counter tcnt (0..NTAPS-1); signed accumulator acc, PROD_W+3 bits; one-entry output register (out_pix, out_valid).
REQ-017 Transfer with tcnt<NTAPS-1 and in_last low: acc gets in_prod when tcnt=0, otherwise acc+in_prod; tcnt increments.
REQ-018 Transfer with tcnt=NTAPS-1 and in_last high: sum = acc+in_prod, then res = (sum + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT (floor).
REQ-019 On that same final transfer: res saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], loads into out_pix, out_valid is set, and tcnt returns to 0.
REQ-020 Latency: out_valid rises on the clock edge that accepts the last tap, so it is visible the following cycle.
REQ-021 in_ready is high unless tcnt=NTAPS-1, out_valid is high and out_ready is low; non-final taps are never back-pressured.
REQ-022 Simultaneous handoff and final-tap load in one cycle: the new result replaces the old one and out_valid stays high, giving full throughput.
REQ-023 Handoff without a load clears out_valid.
REQ-024 out_pix holds its value while out_valid is high and out_ready is low.
REQ-025 Framing error is either case: in_last high on a transfer with tcnt<NTAPS-1, or in_last low on a transfer with tcnt=NTAPS-1.
REQ-026 On a framing error: err pulses high for one cycle, the partial sum is discarded, tcnt returns to 0, and the output register is unaffected.
REQ-027 acc never overflows: NTAPS products of PROD_W bits fit in PROD_W+3 bits.
REQ-028 in_prod, in_last and out_ready are ignored in cycles with no transfer or handoff; in_valid low freezes tcnt and acc.

Reset
REQ-029 While rst is high: tcnt=0, acc=0, out_pix=0, out_valid=0, err=0, and in_ready is high.
REQ-030 Reset asserted mid-sample discards every accepted tap and any pending output; the first transfer after release is tap 0.

Verification
REQ-031 Six taps of +10 with last on tap 5 and out_ready=1 -> out_pix=1 ((60+32)>>6), out_valid high for one cycle, err=0.
REQ-032 Taps {0,0,8128,0,0,0} -> out_pix=127; taps {0,0,-8192,0,0,0} -> out_pix=-128.
REQ-033 Saturation: taps {0,0,8128,8128,0,0} -> res=254, out_pix=127; taps {-8192,-8192,0,0,0,0} -> out_pix=-128.
REQ-034 out_ready=0 with out_valid=1, then a new sample streamed -> taps 0..4 accepted, in_ready low at tap 5; on out_ready=1 the old value is handed off and the new one loaded in the same cycle.
REQ-035 in_last on tap 2 -> err one pulse, no out_valid; the next six-tap sample of +64 -> out_pix=6 ((384+32)>>6).
REQ-036 rst pulsed after 3 taps with out_valid high -> out_valid=0 and out_pix=0 immediately; the next six taps of +10 -> out_pix=1.
